// File: rtl/mmio_key_io.sv
// -----------------------------------------------------------------------------
// mmio_key_io
//
// Memory-mapped I/O block on the MEM-stage I/O port of the pipelined CPU.
// It provides:
//   - KEYS debounced push-button channels with latched press events,
//   - a blocking "wait for key" read that stalls the pipeline until a press
//     is pending,
//   - switch readback,
//   - LED and seven-segment registers, with software-controlled LED blinking,
//   - a registered read path.
//
// Register map (io_addr[4:2]):
//   0 SW        RO   zero-extended synchronised switches
//   1 KEY_PEND  W1C  latched press events (set wins over clear)
//   2 KEY_LVL   RO   debounced key levels
//   3 LED       RW   LED register
//   4 SEG       RW   seven-segment value
//   5 BLINK     RW   bit0 enable, bits[BLINK_W:1] period
//   6 KEY_WAIT  RO   blocking: {1, 27'b0, lowest pending key index}
//   7 -              reads 0, writes ignored
//
// Ports:
//   clk        CPU clock, all state on rising edge
//   rst        asynchronous active-low reset
//   io_we      write strobe (one cycle per write)
//   io_re      read request (held stable by the master while stalled)
//   io_addr    byte address, only bits [4:2] decoded
//   io_wdata   write data
//   io_rdata   registered read data
//   stall_req  pipeline stall request, combinational
//   key_in     raw active-high push buttons
//   sw_in      raw switches
//   led_out    LED drive (blink-gated LED register)
//   seg_data   value for the seven-segment driver
//
// Parameter limits: KEYS 1..16, SW_W <= 32, LED_W <= 32, DEB_CYCLES >= 1,
// BLINK_W <= 31 (the period field sits above the enable bit).
// -----------------------------------------------------------------------------
module mmio_key_io #(
    parameter int KEYS       = 4,
    parameter int SW_W       = 24,
    parameter int LED_W      = 24,
    parameter int DEB_CYCLES = 16,
    parameter int BLINK_W    = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             io_we,
    input  logic             io_re,
    input  logic [31:0]      io_addr,
    input  logic [31:0]      io_wdata,
    output logic [31:0]      io_rdata,
    output logic             stall_req,
    input  logic [KEYS-1:0]  key_in,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] led_out,
    output logic [31:0]      seg_data
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        REG_SW       = 3'd0,
        REG_KEY_PEND = 3'd1,
        REG_KEY_LVL  = 3'd2,
        REG_LED      = 3'd3,
        REG_SEG      = 3'd4,
        REG_BLINK    = 3'd5,
        REG_KEY_WAIT = 3'd6,
        REG_RSVD     = 3'd7
    } reg_sel_t;

    reg_sel_t sel;
    assign sel = reg_sel_t'(io_addr[4:2]);

    // Address bits outside [4:2] and unused write-data bits are don't-care.
    logic unused_bits;
    assign unused_bits = ^{io_addr[31:5], io_addr[1:0], io_wdata};

    // -------------------------------------------------------------------------
    // Input synchronisers
    // -------------------------------------------------------------------------
    logic [KEYS-1:0] key_s1, key_s2;
    logic [SW_W-1:0] sw_s1, sw_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_s1 <= '0;
            key_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= key_in;
            key_s2 <= key_s1;
            sw_s1  <= sw_in;
            sw_s2  <= sw_s1;
        end
    end

    // -------------------------------------------------------------------------
    // Per-key debounce: the level only follows the synchronised input after
    // DEB_CYCLES consecutive disagreeing samples; any agreeing sample restarts.
    // -------------------------------------------------------------------------
    logic [KEYS-1:0] key_lvl;

    for (genvar g = 0; g < KEYS; g++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             lvl;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (key_s2[g] != lvl) begin
                if (cnt == CNT_LAST) begin
                    lvl <= key_s2[g];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end

        assign key_lvl[g] = lvl;
    end

    // -------------------------------------------------------------------------
    // Press events and KEY_WAIT handshake
    // -------------------------------------------------------------------------
    logic [KEYS-1:0] key_lvl_d;
    logic [KEYS-1:0] key_pend;
    logic [KEYS-1:0] pend_set;
    logic [KEYS-1:0] pend_w1c;
    logic [KEYS-1:0] pend_wait_clr;
    logic [3:0]      wait_idx;
    logic            pend_any;
    logic            rd_take;

    assign pend_set = key_lvl & ~key_lvl_d;
    assign pend_any = |key_pend;

    // Scan from the top so the last assignment is the lowest pending bit.
    always_comb begin
        wait_idx = 4'd0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (key_pend[i]) begin
                wait_idx = 4'(i);
            end
        end
    end

    // Held low during reset so a KEY_WAIT presented then only stalls once
    // reset has been released.
    assign stall_req = rst && io_re && (sel == REG_KEY_WAIT) && !pend_any;
    assign rd_take   = io_re && !stall_req;

    assign pend_w1c = (io_we && sel == REG_KEY_PEND) ? io_wdata[KEYS-1:0] : '0;

    always_comb begin
        pend_wait_clr = '0;
        for (int i = 0; i < KEYS; i++) begin
            pend_wait_clr[i] = rd_take && (sel == REG_KEY_WAIT) && (wait_idx == 4'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_lvl_d <= '0;
            key_pend  <= '0;
        end else begin
            key_lvl_d <= key_lvl;
            // A new press on a bit being cleared this cycle must not be lost.
            key_pend  <= (key_pend & ~(pend_w1c | pend_wait_clr)) | pend_set;
        end
    end

    // -------------------------------------------------------------------------
    // LED / SEG / BLINK registers and blink generator
    // -------------------------------------------------------------------------
    logic [LED_W-1:0]   led_reg;
    logic [31:0]        seg_reg;
    logic               blink_en;
    logic [BLINK_W-1:0] blink_per;
    logic [BLINK_W-1:0] blink_presc;
    logic               blink_phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_reg <= '0;
            seg_reg <= '0;
        end else if (io_we) begin
            if (sel == REG_LED) begin
                led_reg <= io_wdata[LED_W-1:0];
            end
            if (sel == REG_SEG) begin
                seg_reg <= io_wdata;
            end
        end
    end

    // Phase 1 shows the LEDs, phase 0 blanks them; a BLINK write restarts the
    // pattern in the visible phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_en    <= 1'b0;
            blink_per   <= '0;
            blink_presc <= '0;
            blink_phase <= 1'b1;
        end else if (io_we && sel == REG_BLINK) begin
            blink_en    <= io_wdata[0];
            blink_per   <= io_wdata[BLINK_W:1];
            blink_presc <= '0;
            blink_phase <= 1'b1;
        end else if (blink_en) begin
            if (blink_presc == blink_per) begin
                blink_presc <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_presc <= blink_presc + 1'b1;
            end
        end else begin
            blink_presc <= '0;
        end
    end

    assign led_out  = (blink_en && !blink_phase) ? '0 : led_reg;
    assign seg_data = seg_reg;

    // -------------------------------------------------------------------------
    // Read path: the mux sees pre-write register values, so a same-cycle
    // write and read returns the old contents.
    // -------------------------------------------------------------------------
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        case (sel)
            REG_SW:       rd_val[SW_W-1:0]  = sw_s2;
            REG_KEY_PEND: rd_val[KEYS-1:0]  = key_pend;
            REG_KEY_LVL:  rd_val[KEYS-1:0]  = key_lvl;
            REG_LED:      rd_val[LED_W-1:0] = led_reg;
            REG_SEG:      rd_val            = seg_reg;
            REG_BLINK: begin
                rd_val[BLINK_W:1] = blink_per;
                rd_val[0]         = blink_en;
            end
            REG_KEY_WAIT: rd_val = {1'b1, 27'b0, wait_idx};
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_rdata <= '0;
        end else if (rd_take) begin
            io_rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_mmio_key_io.sv
module tb_mmio_key_io;

    localparam int KEYS    = 4;
    localparam int SW_W    = 24;
    localparam int LED_W   = 24;
    localparam int DEB     = 16;
    localparam int BLINK_W = 24;

    // Raw edge to pend visible: 2 sync stages + debounce + event latch.
    localparam int PRESS_LAT = 2 + DEB + 1;

    localparam logic [31:0] A_SW    = 32'h00;
    localparam logic [31:0] A_PEND  = 32'h04;
    localparam logic [31:0] A_LVL   = 32'h08;
    localparam logic [31:0] A_LED   = 32'h0C;
    localparam logic [31:0] A_SEG   = 32'h10;
    localparam logic [31:0] A_BLINK = 32'h14;
    localparam logic [31:0] A_WAIT  = 32'h18;
    localparam logic [31:0] A_NONE  = 32'h1C;

    logic             clk = 1'b0;
    logic             rst;
    logic             io_we;
    logic             io_re;
    logic [31:0]      io_addr;
    logic [31:0]      io_wdata;
    logic [31:0]      io_rdata;
    logic             stall_req;
    logic [KEYS-1:0]  key_in;
    logic [SW_W-1:0]  sw_in;
    logic [LED_W-1:0] led_out;
    logic [31:0]      seg_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmio_key_io #(
        .KEYS(KEYS), .SW_W(SW_W), .LED_W(LED_W), .DEB_CYCLES(DEB), .BLINK_W(BLINK_W)
    ) dut (
        .clk(clk), .rst(rst), .io_we(io_we), .io_re(io_re), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .stall_req(stall_req),
        .key_in(key_in), .sw_in(sw_in), .led_out(led_out), .seg_data(seg_data)
    );

    // Bus helpers: called just after a negedge, return just after a negedge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        io_we = 1'b1; io_addr = a; io_wdata = d;
        @(negedge clk);
        io_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        io_re = 1'b1; io_addr = a;
        @(negedge clk);
        io_re = 1'b0;
        d = io_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus_write(A_LED, 32'h00FF_FFFF);
        bus_write(A_SEG, $urandom | 32'h1);
        bus_read(A_LED, d);
        n_cmp++; if (d !== 32'h00FF_FFFF) begin n_err++; $display("FAIL pre_reset_led_read: got %h expected %h", d, 32'h00FF_FFFF); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (led_out !== '0) begin n_err++; $display("FAIL reset_led_out: got %h expected 0", led_out); end
        n_cmp++; if (seg_data !== 32'h0) begin n_err++; $display("FAIL reset_seg_data: got %h expected 0", seg_data); end
        n_cmp++; if (io_rdata !== 32'h0) begin n_err++; $display("FAIL reset_io_rdata: got %h expected 0", io_rdata); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_read(A_PEND, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_pend: got %h expected 0", d); end
        bus_read(A_LVL, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_lvl: got %h expected 0", d); end
        bus_read(A_BLINK, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_blink: got %h expected 0", d); end
    endtask

    task automatic test_debounce();
        logic [31:0]     d;
        logic [KEYS-1:0] mask;
        int k, len, first;
        for (int it = 0; it < 2; it++) begin
            k = (it == 0) ? 2 : $urandom_range(0, KEYS - 1);
            mask = '0;
            mask[k] = 1'b1;
            for (int g = 0; g < 3; g++) begin
                len = (g == 0) ? 10 : $urandom_range(1, DEB - 1);
                key_in[k] = 1'b1; idle(len);
                key_in[k] = 1'b0; idle(DEB + 4);
            end
            bus_read(A_LVL, d);
            n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL glitch_lvl: key %0d got %h expected 0", k, d); end
            bus_read(A_PEND, d);
            n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL glitch_pend: key %0d got %h expected 0", k, d); end

            // Continuous KEY_PEND reads while the key is held for 40 cycles.
            io_re = 1'b1; io_addr = A_PEND;
            key_in[k] = 1'b1;
            first = -1;
            for (int c = 1; c <= 60; c++) begin
                @(negedge clk);
                if (first < 0 && c < 30 && io_rdata[k] === 1'b1) first = c;
                if (c == 30) io_addr = A_LVL;
                if (c == 31) begin
                    n_cmp++; if (io_rdata !== 32'(mask)) begin n_err++; $display("FAIL held_lvl: got %h expected %h", io_rdata, 32'(mask)); end
                    io_addr = A_PEND;
                end
                if (c == 40) key_in[k] = 1'b0;
            end
            io_re = 1'b0;
            // +1 for the registered read path.
            n_cmp++; if (first !== PRESS_LAT + 1) begin n_err++; $display("FAIL press_latency: got %0d expected %0d", first, PRESS_LAT + 1); end
            n_cmp++; if (io_rdata !== 32'(mask)) begin n_err++; $display("FAIL pend_after_release: got %h expected %h", io_rdata, 32'(mask)); end
            idle(DEB + 4);
            bus_read(A_LVL, d);
            n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL released_lvl: got %h expected 0", d); end
            bus_write(A_PEND, 32'(mask));
            bus_read(A_PEND, d);
            n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL w1c_clear: got %h expected 0", d); end
        end
    endtask

    task automatic test_key_wait();
        logic [31:0] d, hold, exp;
        int k, c, stalled;
        for (int it = 0; it < 2; it++) begin
            k = (it == 0) ? 1 : $urandom_range(0, KEYS - 1);
            hold = io_rdata;
            io_re = 1'b1; io_addr = A_WAIT;
            #1;
            n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL wait_stall_start: got %b expected 1", stall_req); end
            stalled = 0;
            repeat (50) begin
                @(negedge clk);
                if (stall_req === 1'b1) stalled++;
            end
            n_cmp++; if (stalled != 50) begin n_err++; $display("FAIL wait_stall_cycles: got %0d expected 50", stalled); end
            n_cmp++; if (io_rdata !== hold) begin n_err++; $display("FAIL wait_rdata_hold: got %h expected %h", io_rdata, hold); end
            key_in[k] = 1'b1;
            c = 0;
            while (stall_req !== 1'b0 && c < 100) begin
                @(negedge clk);
                c++;
            end
            n_cmp++; if (c != PRESS_LAT) begin n_err++; $display("FAIL wait_release_cycle: got %0d expected %0d", c, PRESS_LAT); end
            @(negedge clk);
            io_re = 1'b0;
            exp = 32'h8000_0000 | 32'(k);
            n_cmp++; if (io_rdata !== exp) begin n_err++; $display("FAIL wait_rdata: got %h expected %h", io_rdata, exp); end
            key_in[k] = 1'b0;
            idle(PRESS_LAT + 2);
            bus_read(A_PEND, d);
            n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL wait_pend_cleared: got %h expected 0", d); end
        end
    endtask

    task automatic test_priority();
        logic [KEYS-1:0] mask;
        logic [31:0]     d, exp;
        int              exp_q[$];
        for (int it = 0; it < 2; it++) begin
            mask = (it == 0) ? 4'b1010 : KEYS'($urandom_range(1, (1 << KEYS) - 1));
            key_in = mask; idle(PRESS_LAT + 2);
            key_in = '0;   idle(PRESS_LAT + 2);
            bus_read(A_PEND, d);
            n_cmp++; if (d !== 32'(mask)) begin n_err++; $display("FAIL prio_pend: got %h expected %h", d, 32'(mask)); end
            exp_q.delete();
            for (int i = 0; i < KEYS; i++) if (mask[i]) exp_q.push_back(i);
            while (exp_q.size() > 0) begin
                exp = 32'h8000_0000 | 32'(exp_q.pop_front());
                io_re = 1'b1; io_addr = A_WAIT;
                #1;
                n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL prio_no_stall: got %b expected 0", stall_req); end
                @(negedge clk);
                io_re = 1'b0;
                n_cmp++; if (io_rdata !== exp) begin n_err++; $display("FAIL prio_wait_rdata: got %h expected %h", io_rdata, exp); end
            end
            bus_read(A_PEND, d);
            n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL prio_pend_empty: got %h expected 0", d); end
            io_re = 1'b1; io_addr = A_WAIT;
            #1;
            n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL prio_stall_empty: got %b expected 1", stall_req); end
            io_re = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_blink();
        logic [LED_W-1:0] led, exp;
        logic [31:0]      d;
        int               p;
        for (int it = 0; it < 2; it++) begin
            led = (it == 0) ? 24'h0000A5 : LED_W'($urandom | 1);
            p   = (it == 0) ? 3 : $urandom_range(0, 5);
            bus_write(A_LED, 32'(led));
            bus_write(A_BLINK, (32'(p) << 1) | 32'd1);
            // Each phase lasts P+1 cycles, starting visible after the write.
            for (int j = 0; j < 4 * (p + 1); j++) begin
                exp = (((j / (p + 1)) % 2) == 0) ? led : '0;
                n_cmp++; if (led_out !== exp) begin n_err++; $display("FAIL blink_led: P=%0d cycle %0d got %h expected %h", p, j, led_out, exp); end
                @(negedge clk);
            end
            bus_read(A_BLINK, d);
            n_cmp++; if (d !== ((32'(p) << 1) | 32'd1)) begin n_err++; $display("FAIL blink_readback: got %h expected %h", d, (32'(p) << 1) | 32'd1); end
            bus_write(A_BLINK, 32'h0);
            for (int j = 0; j < 6; j++) begin
                n_cmp++; if (led_out !== led) begin n_err++; $display("FAIL blink_off_led: cycle %0d got %h expected %h", j, led_out, led); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_map();
        logic [SW_W-1:0]  sw;
        logic [LED_W-1:0] led_a, led_b;
        logic [31:0]      d, seg;
        for (int it = 0; it < 2; it++) begin
            sw = (it == 0) ? 24'h123456 : SW_W'($urandom);
            sw_in = sw;
            idle(3);
            bus_read(A_SW, d);
            n_cmp++; if (d !== 32'(sw)) begin n_err++; $display("FAIL sw_read: got %h expected %h", d, 32'(sw)); end
        end
        bus_read(A_NONE, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL addr7_read: got %h expected 0", d); end
        led_a = LED_W'($urandom);
        bus_write(A_LED, 32'(led_a));
        bus_write(A_NONE, $urandom | 32'h1);
        bus_read(A_NONE, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL addr7_after_write: got %h expected 0", d); end
        bus_read(A_LED, d);
        n_cmp++; if (d !== 32'(led_a)) begin n_err++; $display("FAIL led_readback: got %h expected %h", d, 32'(led_a)); end
        seg = $urandom;
        bus_write(A_SEG, seg);
        n_cmp++; if (seg_data !== seg) begin n_err++; $display("FAIL seg_data: got %h expected %h", seg_data, seg); end
        bus_read(A_SEG, d);
        n_cmp++; if (d !== seg) begin n_err++; $display("FAIL seg_readback: got %h expected %h", d, seg); end

        // Same-cycle write and read of LED returns the old value.
        led_b = ~led_a;
        io_we = 1'b1; io_re = 1'b1; io_addr = A_LED; io_wdata = 32'(led_b);
        @(negedge clk);
        io_we = 1'b0; io_re = 1'b0;
        n_cmp++; if (io_rdata !== 32'(led_a)) begin n_err++; $display("FAIL rw_collision_rdata: got %h expected %h", io_rdata, 32'(led_a)); end
        n_cmp++; if (led_out !== led_b) begin n_err++; $display("FAIL rw_collision_led: got %h expected %h", led_out, led_b); end

        // W1C of bit0 lands on the very edge its new press is latched.
        key_in[0] = 1'b1;
        idle(PRESS_LAT - 1);
        bus_write(A_PEND, 32'h1);
        key_in[0] = 1'b0;
        bus_read(A_PEND, d);
        n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL set_beats_clear: got %h expected %h", d, 32'h1); end
        idle(PRESS_LAT + 2);
        bus_write(A_PEND, 32'hFFFF_FFFF);
        bus_read(A_PEND, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL final_clear: got %h expected 0", d); end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; io_we = 1'b0; io_re = 1'b0; io_addr = '0; io_wdata = '0;
        key_in = '0; sw_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_debounce();
        test_key_wait();
        test_priority();
        test_blink();
        test_map();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_key_io.md
# mmio_key_io

Parametrised memory-mapped I/O controller on the MEM-stage I/O port of the pipelined CPU. Generalises the fixed two-button / switch / LED / seven-segment I/O into KEYS debounced push-button channels with latched press events, a blocking "wait for key" read that stalls the pipeline, software-controlled LED blinking and a registered read path. Sits between the MEM stage's io_* bus and the board pins; its seg and LED outputs feed the display driver.

## Interface
- KEYS, 4: number of push-button channels (1..16).
- SW_W, 24: switch input width (≤32).
- LED_W, 24: LED output width (≤32).
- DEB_CYCLES, 16: consecutive stable cycles required to accept a key level change (≥1).
- BLINK_W, 24: blink prescaler counter width.

- clk  input  1  CPU clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- io_we  input  1  write strobe, one cycle per write.
- io_re  input  1  read request.
- io_addr  input  32  byte address; only bits [4:2] decoded.
- io_wdata  input  32  write data.
- io_rdata  output  32  read data, registered.
- stall_req  output  1  pipeline stall request (to CTRL).
- key_in  input  KEYS  raw active-high buttons.
- sw_in  input  SW_W  raw switches.
- led_out  output  LED_W  LED drive.
- seg_data  output  32  value for the seven-segment driver.

## Operation
- Input sync: key_in and sw_in each pass a 2-FF synchroniser; sw_sync is register-visible.
- Debounce per key i: counter cnt[i], stable level lvl[i]. If sync != lvl, cnt increments; on cnt reaching DEB_CYCLES-1 with sync still != lvl, lvl <= sync and cnt clears. If sync == lvl, cnt clears. A glitch shorter than DEB_CYCLES never changes lvl.
- Event latch: lvl[i] 0->1 sets pend[i]. Release sets nothing.
- Register map (io_addr[4:2]):
  - 0 SW (RO): zero-extended sw_sync.
  - 1 KEY_PEND: read pend; write 1-to-clear. Same-cycle set and clear on a bit: set wins.
  - 2 KEY_LVL (RO): lvl.
  - 3 LED (RW): led_reg[LED_W-1:0].
  - 4 SEG (RW): seg_reg, drives seg_data.
  - 5 BLINK (RW): bit0 enable, bits[BLINK_W:1] period P.
  - 6 KEY_WAIT (RO, blocking): see below.
  - 7: reads 0, writes ignored.
- KEY_WAIT: while io_re && addr==6 && pend==0, stall_req=1 (combinational); master holds io_re/io_addr stable. When pend!=0, stall_req=0 and the read completes: io_rdata <= {1'b1, 27'b0, idx[3:0]} where idx = lowest set pend bit; that pend bit clears in the same edge (a new set on the same bit that cycle wins).
- Blink: when enabled, prescaler counts 0..P then wraps and toggles phase. led_out = (en && !phase) ? 0 : led_reg. P==0 toggles every cycle. Writing BLINK clears prescaler and sets phase=1. Disabled: led_out=led_reg, prescaler held at 0.
- Simultaneous io_we and io_re: write performed; read returns pre-write value.

## Timing
- Reset (rst=0, async): io_rdata=0, led_reg=0, seg_reg=0, blink en=0, P=0, phase=1, pend=0, lvl=0, cnt=0, sync FFs=0, stall_req=0 (combinational on cleared pend, so high if a KEY_WAIT read is presented during reset release only after rst=1).
- Read latency: io_rdata valid the edge after an accepted read (io_re with stall_req=0); holds value otherwise.
- Write: takes effect at the edge where io_we=1; visible on led_out/seg_data next cycle.
- Key press to pend set: 2 (sync) + DEB_CYCLES + 1 cycles after the raw edge.
- Stalled KEY_WAIT completes at the first edge with pend!=0; stall_req drops in that cycle combinationally.
- Reset mid-stall: pend cleared, stall ends only by a new press after reset.

## Test plan
- Reset: assert rst=0 mid-run with led_reg=0xFFFFFF -> led_out=0, seg_data=0, io_rdata=0 immediately, no clock needed.
- Debounce: key_in[2] pulses high 10 cycles (DEB_CYCLES=16) -> KEY_LVL=0, KEY_PEND=0; held 40 cycles -> KEY_PEND=0x4 exactly 19 cycles after rising edge; write 0x4 to KEY_PEND -> reads 0.
- KEY_WAIT blocking: read addr 0x18 with no pend -> stall_req=1 for 50 cycles; press key 1 -> stall_req falls, io_rdata=0x80000001, KEY_PEND bit1 cleared.
- Priority: pend=0b1010, KEY_WAIT twice -> 0x80000001 then 0x80000003, pend=0.
- Blink: LED=0x00A5, BLINK=(3<<1)|1 -> led_out alternates 0x00A5/0x0000 every 4 cycles; BLINK=0 -> steady 0x00A5.
- Map/collision: sw_in=0x123456 -> SW reads 0x00123456 after ≥3 cycles; addr 0x1C reads 0; same-cycle W1C and new press on bit0 -> bit0 remains 1.
